game_timer: RTL and testbench
=============================

Name: game_timer

Overview:
- Consumer of the one-second / half-second tick generator; the reading end of the tick interface.
- Counts the round clock down from a configured m:ss start value while the game is in the PLAY state (state==2'b01).
- Drives BCD digits to the 7-segment display and a low-time blink flag to the display/LED logic.
- Signals end of round to the top-level game FSM.

Parameters:
- START_MIN, 1, start minutes digit (0-9).
- START_SEC, 0, start seconds (0-59).
- WARN_SEC, 10, remaining-seconds threshold at or below which warn_blink toggles (1-59).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous active-high reset
- state  in  2  game state; 2'b01 = PLAY
- pause  in  1  game paused; ticks ignored while high
- one_second_enable  in  1  one-second tick from the tick generator (level; may stay high many cycles)
- half_second  in  1  half-second tick (level; may stay high many cycles)
- min_bcd  out  4  minutes digit
- sec_tens  out  4  seconds tens digit (0-5)
- sec_ones  out  4  seconds ones digit (0-9)
- running  out  1  high in RUN
- time_up  out  1  high in EXPIRED
- time_up_pulse  out  1  one-cycle strobe on entering EXPIRED
- warn_blink  out  1  low-time blink flag

Behaviour:
- Reset (async, any time):
  - Digits = START_MIN : START_SEC split as tens/ones.
  - running=0, time_up=0, time_up_pulse=0, warn_blink=0.
  - Edge registers = 0; FSM = IDLE.
- Tick inputs are levels. The tick source holds its count while paused, so a tick can stay high for many cycles.
  - Register both inputs: tick_d, half_d.
  - Act only on rising edges: tick_rise = one_second_enable & ~tick_d; half_rise = half_second & ~half_d.
- FSM states: IDLE, RUN, EXPIRED. All outputs are registered.
- IDLE:
  - Digits reload to start value every cycle; running=0, time_up=0, warn_blink=0.
  - state==01 -> RUN next cycle.
  - If the start value is 0:00 -> EXPIRED instead, with time_up_pulse.
- RUN:
  - running=1.
  - On tick_rise with pause=0, decrement BCD:
    - ones>0: ones-1.
    - else ones=9; if tens>0: tens-1.
    - else tens=5 and min-1.
  - tick_rise while pause=1 is discarded, not deferred.
  - A decrement that produces 0:00 moves the FSM to EXPIRED on the same edge. time_up_pulse is high for exactly the following cycle.
  - state!=01 -> IDLE; digits reload on that edge, taking priority over a simultaneous tick.
- EXPIRED:
  - Digits hold 0:00; time_up=1; running=0; warn_blink=1 steady.
  - Ticks are ignored.
  - state!=01 -> IDLE with reload.
- warn_blink in RUN:
  - If remaining total seconds (min*60 + tens*10 + ones) <= WARN_SEC and pause=0: toggles on each half_rise.
  - Otherwise forced to 0.
  - Remaining seconds are computed combinationally from the registered digits, 10-bit width.
- Digits never leave legal BCD ranges. Underflow below 0:00 is impossible by construction.

Optional Feature:
- Macro: GAME_TIMER_BONUS_EN.
- With the macro:
  - Adds input port add_bonus (1 bit).
  - A rising edge of add_bonus in RUN with pause=0 adds 5 seconds, with BCD carry; result saturates at 9:59.
  - A simultaneous tick_rise gives net +4 s.
  - Ignored in IDLE and EXPIRED.
- Without the macro: the port and its logic are absent; behaviour is exactly as above.

Test Plan:
- Defaults; rst pulse; state=01; 60 isolated tick rises -> digits 0:59 after the 1st, 0:00 after the 60th. time_up_pulse is high for 1 cycle, then time_up=1 and running=0.
- one_second_enable held high for 1000 cycles in RUN at 1:00 -> exactly one decrement, to 0:59.
- Tick rise with pause=1 at 0:45 -> stays 0:45. Next rise with pause=0 -> 0:44.
- At 0:11 a half_rise -> warn_blink=0. Decrement to 0:10, then 4 half_rise -> warn_blink toggles 1,0,1,0. At 0:00 -> warn_blink=1 steady.
- At 0:37 in RUN, state=2'b00 on the same cycle as a tick rise -> next cycle digits 1:00, running=0, time_up=0. Returning state to 01 restarts from 1:00.
- Async rst asserted mid-clock at 0:05 -> outputs reload to 1:00 without waiting for a clk edge. GAME_TIMER_BONUS_EN build: add_bonus at 9:57 -> 9:59 (saturate).

Source files
------------

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
//
// Round clock for the game. It counts an m:ss value down from a configured
// start value while the game FSM reports PLAY. It takes the one-second and
// half-second ticks from the tick generator and drives:
//   - BCD digits for the 7-segment display
//   - a low-time blink flag
//   - end-of-round indications for the top-level FSM
//
// Optional feature, enabled by defining GAME_TIMER_BONUS_EN:
//   - Adds an add_bonus input.
//   - A rising edge of add_bonus while running and not paused adds five
//     seconds. The result saturates at 9:59.
//
// Parameters:
//   START_MIN  start minutes digit (0-9)
//   START_SEC  start seconds (0-59)
//   WARN_SEC   remaining seconds at or below which warn_blink toggles (1-59)
//
// Ports:
//   clk                in   system clock
//   rst                in   asynchronous active-high reset
//   state[1:0]         in   game state, 2'b01 = PLAY
//   pause              in   game paused; ticks and bonus ignored while high
//   one_second_enable  in   one-second tick (level, acted on at rising edge)
//   half_second        in   half-second tick (level, acted on at rising edge)
//   add_bonus          in   +5 s request (only with GAME_TIMER_BONUS_EN)
//   min_bcd[3:0]       out  minutes digit
//   sec_tens[3:0]      out  seconds tens digit (0-5)
//   sec_ones[3:0]      out  seconds ones digit (0-9)
//   running            out  high while counting (RUN)
//   time_up            out  high while the round is over (EXPIRED)
//   time_up_pulse      out  one-cycle strobe on entering EXPIRED
//   warn_blink         out  low-time blink flag
// -----------------------------------------------------------------------------
module game_timer #(
  parameter int START_MIN = 1,
  parameter int START_SEC = 0,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       pause,
  input  logic       one_second_enable,
  input  logic       half_second,
`ifdef GAME_TIMER_BONUS_EN
  input  logic       add_bonus,
`endif
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up,
  output logic       time_up_pulse,
  output logic       warn_blink
);

  localparam logic [1:0]  PLAY         = 2'b01;
  localparam logic [3:0]  START_MIN_C  = 4'(START_MIN);
  localparam logic [3:0]  START_TENS_C = 4'(START_SEC / 10);
  localparam logic [3:0]  START_ONES_C = 4'(START_SEC % 10);
  localparam logic [11:0] START_DIGITS = {START_MIN_C, START_TENS_C, START_ONES_C};
  localparam logic [11:0] ZERO_DIGITS  = 12'h000;
  localparam bit          START_ZERO   = (START_MIN == 0) && (START_SEC == 0);
  localparam logic [9:0]  WARN_C       = 10'(WARN_SEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } fsm_e;

  fsm_e        state_q, state_d;
  // Digits packed as {minutes, seconds tens, seconds ones}.
  logic [11:0] digits_q, digits_d;
  logic        running_q, running_d;
  logic        time_up_q, time_up_d;
  logic        pulse_q, pulse_d;
  logic        warn_q, warn_d;
  logic        tick_prev_q, half_prev_q;

  logic        tick_rise;
  logic        half_rise;
  logic        play;
  logic        dec_fire;
  logic [9:0]  rem_sec;

  // One-second decrement with BCD borrow.
  // The caller guarantees the input is not 0:00.
  function automatic logic [11:0] bcd_dec(input logic [11:0] d);
    logic [3:0] m, t, o;
    m = d[11:8];
    t = d[7:4];
    o = d[3:0];
    if (o != 4'd0) begin
      o = o - 4'd1;
    end else begin
      o = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd5;
        m = m - 4'd1;
      end
    end
    return {m, t, o};
  endfunction

`ifdef GAME_TIMER_BONUS_EN
  localparam logic [9:0]  MAX_SEC    = 10'd599;
  localparam logic [11:0] MAX_DIGITS = 12'h959;

  logic bonus_prev_q;
  logic bonus_rise;

  // BCD add of a small amount (at most 5), so at most one carry per digit.
  // Saturation is decided on the binary total to avoid a minutes overflow.
  function automatic logic [11:0] bcd_add(input logic [11:0] d,
                                          input logic [2:0]  amt,
                                          input logic [9:0]  total);
    logic [3:0] m, t, o;
    logic [4:0] o_sum;
    if (total + 10'(amt) > MAX_SEC) begin
      return MAX_DIGITS;
    end
    m     = d[11:8];
    t     = d[7:4];
    o_sum = 5'(d[3:0]) + 5'(amt);
    if (o_sum >= 5'd10) begin
      o = 4'(o_sum - 5'd10);
      if (t == 4'd5) begin
        t = 4'd0;
        m = m + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = 4'(o_sum);
    end
    return {m, t, o};
  endfunction

  assign bonus_rise = add_bonus & ~bonus_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bonus_prev_q <= 1'b0;
    end else begin
      bonus_prev_q <= add_bonus;
    end
  end

  // A bonus coinciding with a tick is folded into a single +4 add.
  assign dec_fire = tick_rise & ~bonus_rise & (digits_q != ZERO_DIGITS);
`else
  assign dec_fire = tick_rise & (digits_q != ZERO_DIGITS);
`endif

  // Ticks are levels that may stay high for many cycles; only edges count.
  assign tick_rise = one_second_enable & ~tick_prev_q;
  assign half_rise = half_second & ~half_prev_q;
  assign play      = (state == PLAY);

  assign rem_sec = 10'(digits_q[11:8]) * 10'd60
                 + 10'(digits_q[7:4])  * 10'd10
                 + 10'(digits_q[3:0]);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and digit logic.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    case (state_q)
      S_IDLE: begin
        digits_d = START_DIGITS;
        if (play) begin
          state_d = START_ZERO ? S_EXPIRED : S_RUN;
        end
      end
      S_RUN: begin
        if (!play) begin
          // Leaving PLAY wins over any tick on the same edge.
          state_d  = S_IDLE;
          digits_d = START_DIGITS;
        end else if (!pause) begin
          if (dec_fire) begin
            digits_d = bcd_dec(digits_q);
            if (digits_d == ZERO_DIGITS) begin
              state_d = S_EXPIRED;
            end
          end
`ifdef GAME_TIMER_BONUS_EN
          if (bonus_rise) begin
            digits_d = bcd_add(digits_q, tick_rise ? 3'd4 : 3'd5, rem_sec);
          end
`endif
        end
      end
      S_EXPIRED: begin
        digits_d = ZERO_DIGITS;
        if (!play) begin
          state_d  = S_IDLE;
          digits_d = START_DIGITS;
        end
      end
      default: begin
        state_d  = S_IDLE;
        digits_d = START_DIGITS;
      end
    endcase
  end

  // Output logic.
  // Outputs are registered, so each value is derived from the state being
  // entered on this edge.
  always_comb begin
    running_d = (state_d == S_RUN);
    time_up_d = (state_d == S_EXPIRED);
    pulse_d   = (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
    warn_d    = 1'b0;
    case (state_d)
      S_RUN: begin
        if ((state_q == S_RUN) && (rem_sec <= WARN_C) && !pause) begin
          warn_d = half_rise ? ~warn_q : warn_q;
        end
      end
      S_EXPIRED: warn_d = 1'b1;
      default:   warn_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q    <= START_DIGITS;
      running_q   <= 1'b0;
      time_up_q   <= 1'b0;
      pulse_q     <= 1'b0;
      warn_q      <= 1'b0;
      tick_prev_q <= 1'b0;
      half_prev_q <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      running_q   <= running_d;
      time_up_q   <= time_up_d;
      pulse_q     <= pulse_d;
      warn_q      <= warn_d;
      tick_prev_q <= one_second_enable;
      half_prev_q <= half_second;
    end
  end

  assign min_bcd       = digits_q[11:8];
  assign sec_tens      = digits_q[7:4];
  assign sec_ones      = digits_q[3:0];
  assign running       = running_q;
  assign time_up       = time_up_q;
  assign time_up_pulse = pulse_q;
  assign warn_blink    = warn_q;

endmodule

// File: tb/tb_game_timer.sv
// -----------------------------------------------------------------------------
// tb_game_timer
//
// Self-checking bench for game_timer with default parameters (1:00, warn 10).
//
// The reference model tracks the remaining time as a plain integer number of
// seconds and converts it to m:ss only for comparison.
//
// Define GAME_TIMER_BONUS_EN to also drive and check add_bonus.
// -----------------------------------------------------------------------------
module tb_game_timer;

  localparam int START_S = 60;
  localparam int WARN_S  = 10;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_EXP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       pause;
  logic       ose;
  logic       half;
`ifdef GAME_TIMER_BONUS_EN
  logic       add_bonus;
`endif
  logic [3:0] min_bcd, sec_tens, sec_ones;
  logic       running, time_up, time_up_pulse, warn_blink;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode;
  int m_rem;
  bit m_running, m_time_up, m_pulse, m_warn;
  bit m_tick_prev, m_half_prev, m_bonus_prev;

  game_timer dut (
    .clk               (clk),
    .rst               (rst),
    .state             (state),
    .pause             (pause),
    .one_second_enable (ose),
    .half_second       (half),
`ifdef GAME_TIMER_BONUS_EN
    .add_bonus         (add_bonus),
`endif
    .min_bcd           (min_bcd),
    .sec_tens          (sec_tens),
    .sec_ones          (sec_ones),
    .running           (running),
    .time_up           (time_up),
    .time_up_pulse     (time_up_pulse),
    .warn_blink        (warn_blink)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] digits_of(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_rem        = START_S;
    m_running    = 1'b0;
    m_time_up    = 1'b0;
    m_pulse      = 1'b0;
    m_warn       = 1'b0;
    m_tick_prev  = 1'b0;
    m_half_prev  = 1'b0;
    m_bonus_prev = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    bit tr, hr, br, play;
    int old_mode, old_rem;
    if (rst) begin
      model_reset();
      return;
    end
    tr = ose && !m_tick_prev;
    hr = half && !m_half_prev;
    br = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    br = add_bonus && !m_bonus_prev;
    m_bonus_prev = add_bonus;
`endif
    play     = (state == 2'b01);
    old_mode = m_mode;
    old_rem  = m_rem;
    if (m_mode == M_IDLE) begin
      m_rem = START_S;
      if (play) m_mode = (START_S == 0) ? M_EXP : M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!play) begin
        m_mode = M_IDLE;
        m_rem  = START_S;
      end else if (!pause) begin
        if (br) begin
          m_rem = m_rem + (tr ? 4 : 5);
          if (m_rem > 599) m_rem = 599;
        end else if (tr) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = M_EXP;
        end
      end
    end else begin
      if (!play) begin
        m_mode = M_IDLE;
        m_rem  = START_S;
      end
    end
    m_running = (m_mode == M_RUN);
    m_time_up = (m_mode == M_EXP);
    m_pulse   = (m_mode == M_EXP) && (old_mode != M_EXP);
    if (m_mode == M_EXP) m_warn = 1'b1;
    else if (m_mode == M_IDLE) m_warn = 1'b0;
    else if (old_mode == M_RUN && old_rem <= WARN_S && !pause) begin
      if (hr) m_warn = !m_warn;
    end else m_warn = 1'b0;
    m_tick_prev = ose;
    m_half_prev = half;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_tick();
    ose = 1'b1;
    cyc();
    ose = 1'b0;
    cyc();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic start_round();
    state = 2'b00;
    pause = 1'b0;
    ose   = 1'b0;
    half  = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    add_bonus = 1'b0;
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    state = 2'b01;
    cyc();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    state = 2'b00;
    pause = 1'b0;
    ose   = 1'b0;
    half  = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    add_bonus = 1'b0;
`endif
    model_reset();
    cyc();
    cyc();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(START_S)) begin
      errors++;
      $display("FAIL reset_digits: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(START_S));
    end
    checks++;
    if ({running, time_up, time_up_pulse, warn_blink} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000",
               {running, time_up, time_up_pulse, warn_blink});
    end
    $display("reset: digits %h flags %b", {min_bcd, sec_tens, sec_ones},
             {running, time_up, time_up_pulse, warn_blink});
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_countdown();
    start_round();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: running got %b required 1", running);
    end
    for (int i = 1; i <= 60; i++) begin
      ose = 1'b1;
      cyc();
      checks++;
      if ({min_bcd, sec_tens, sec_ones} !== digits_of(60 - i)) begin
        errors++;
        $display("FAIL countdown_%0d: got %h required %h", i,
                 {min_bcd, sec_tens, sec_ones}, digits_of(60 - i));
      end
      $display("countdown tick %0d -> %h", i, {min_bcd, sec_tens, sec_ones});
      if (i == 60) begin
        checks++;
        if ({running, time_up, time_up_pulse} !== 3'b011) begin
          errors++;
          $display("FAIL expire_edge: run/up/pulse got %b required 011",
                   {running, time_up, time_up_pulse});
        end
      end
      ose = 1'b0;
      cyc();
    end
    checks++;
    if ({running, time_up, time_up_pulse, warn_blink} !== 4'b0101) begin
      errors++;
      $display("FAIL expired_hold: run/up/pulse/warn got %b required 0101",
               {running, time_up, time_up_pulse, warn_blink});
    end
    run_ticks(3);
    checks++;
    if ({min_bcd, sec_tens, sec_ones, time_up_pulse} !== {digits_of(0), 1'b0}) begin
      errors++;
      $display("FAIL expired_ticks: digits %h pulse %b required 000 0",
               {min_bcd, sec_tens, sec_ones}, time_up_pulse);
    end
  endtask

  task automatic test_held_tick();
    start_round();
    ose = 1'b1;
    for (int i = 0; i < 1000; i++) cyc();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(59)) begin
      errors++;
      $display("FAIL held_tick: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(59));
    end
    $display("held tick 1000 cycles -> %h", {min_bcd, sec_tens, sec_ones});
    ose = 1'b0;
    cyc();
  endtask

  task automatic test_pause();
    start_round();
    run_ticks(15);
    pause = 1'b1;
    do_tick();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(45)) begin
      errors++;
      $display("FAIL pause_discard: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(45));
    end
    pause = 1'b0;
    cyc();
    do_tick();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(44)) begin
      errors++;
      $display("FAIL pause_resume: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(44));
    end
    $display("pause: discarded tick, resumed -> %h", {min_bcd, sec_tens, sec_ones});
  endtask

  task automatic test_warn();
    bit exp_w;
    start_round();
    run_ticks(49);
    half = 1'b1;
    cyc();
    checks++;
    if (warn_blink !== 1'b0) begin
      errors++;
      $display("FAIL warn_above: got %b required 0", warn_blink);
    end
    half = 1'b0;
    cyc();
    do_tick();
    exp_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_w = !exp_w;
      half = 1'b1;
      cyc();
      checks++;
      if (warn_blink !== exp_w) begin
        errors++;
        $display("FAIL warn_toggle_%0d: got %b required %b", k, warn_blink, exp_w);
      end
      $display("warn half-rise %0d -> %b", k, warn_blink);
      half = 1'b0;
      cyc();
    end
    run_ticks(10);
    for (int k = 0; k < 2; k++) begin
      half = 1'b1;
      cyc();
      half = 1'b0;
      cyc();
    end
    checks++;
    if ({warn_blink, time_up} !== 2'b11) begin
      errors++;
      $display("FAIL warn_expired: warn/up got %b required 11", {warn_blink, time_up});
    end
  endtask

  task automatic test_abort();
    start_round();
    run_ticks(23);
    state = 2'b00;
    ose   = 1'b1;
    cyc();
    checks++;
    if ({min_bcd, sec_tens, sec_ones, running, time_up} !== {digits_of(60), 2'b00}) begin
      errors++;
      $display("FAIL abort_reload: digits %h run/up %b required %h 00",
               {min_bcd, sec_tens, sec_ones}, {running, time_up}, digits_of(60));
    end
    ose   = 1'b0;
    state = 2'b01;
    cyc();
    checks++;
    if ({running, min_bcd, sec_tens, sec_ones} !== {1'b1, digits_of(60)}) begin
      errors++;
      $display("FAIL abort_restart: run %b digits %h required 1 %h",
               running, {min_bcd, sec_tens, sec_ones}, digits_of(60));
    end
    do_tick();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(59)) begin
      errors++;
      $display("FAIL abort_count: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(59));
    end
    $display("abort at 0:37 -> reload, restart -> %h", {min_bcd, sec_tens, sec_ones});
  endtask

  task automatic test_async_reset();
    start_round();
    run_ticks(55);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({min_bcd, sec_tens, sec_ones, running} !== {digits_of(60), 1'b0}) begin
      errors++;
      $display("FAIL async_reset: digits %h run %b required %h 0",
               {min_bcd, sec_tens, sec_ones}, running, digits_of(60));
    end
    $display("async reset mid-cycle -> %h", {min_bcd, sec_tens, sec_ones});
    cyc();
    rst = 1'b0;
    state = 2'b00;
    cyc();
  endtask

`ifdef GAME_TIMER_BONUS_EN
  task automatic test_bonus();
    start_round();
    add_bonus = 1'b1;
    ose       = 1'b1;
    cyc();
    add_bonus = 1'b0;
    ose       = 1'b0;
    cyc();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(64)) begin
      errors++;
      $display("FAIL bonus_net4: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(64));
    end
    for (int i = 0; i < 107; i++) begin
      add_bonus = 1'b1;
      cyc();
      add_bonus = 1'b0;
      cyc();
    end
    run_ticks(2);
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(597)) begin
      errors++;
      $display("FAIL bonus_climb: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(597));
    end
    add_bonus = 1'b1;
    cyc();
    add_bonus = 1'b0;
    cyc();
    checks++;
    if ({min_bcd, sec_tens, sec_ones} !== digits_of(599)) begin
      errors++;
      $display("FAIL bonus_saturate: got %h required %h",
               {min_bcd, sec_tens, sec_ones}, digits_of(599));
    end
    $display("bonus at 9:57 -> %h", {min_bcd, sec_tens, sec_ones});
  endtask
`endif

  task automatic test_random();
    int expiries;
    logic [15:0] got, want;
    expiries = 0;
    start_round();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) ose = ~ose;
      if ($urandom_range(0, 2) == 0) half = ~half;
      pause = ($urandom_range(0, 9) == 0);
`ifdef GAME_TIMER_BONUS_EN
      if ($urandom_range(0, 29) == 0) add_bonus = ~add_bonus;
`endif
      if (state == 2'b01) begin
        if ($urandom_range(0, 1499) == 0 || (m_mode == M_EXP && $urandom_range(0, 19) == 0))
          state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(2, 3));
      end else if ($urandom_range(0, 4) == 0) begin
        state = 2'b01;
      end
      cyc();
      if (m_pulse) expiries++;
      got  = {min_bcd, sec_tens, sec_ones, running, time_up, time_up_pulse, warn_blink};
      want = {digits_of(m_rem), m_running, m_time_up, m_pulse, m_warn};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle_%0d: digits/run/up/pulse/warn got %h required %h",
                 c, got, want);
      end
    end
    $display("random: 4000 cycles, %0d expiries", expiries);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_held_tick();
    test_pause();
    test_warn();
    test_abort();
    test_async_reset();
`ifdef GAME_TIMER_BONUS_EN
    test_bonus();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
